// File: rtl/dmem_bridge_pkg.sv
// Shared widths, bus FSM encodings and helpers for the data-memory bridge.
package dmem_bridge_pkg;

  localparam int unsigned WORD_WIDTH = 32;

  // Bus FSM state encodings
  localparam logic [1:0] B_IDLE_ENC   = 2'd0;
  localparam logic [1:0] B_WR_ENC     = 2'd1;
  localparam logic [1:0] B_RD_ENC     = 2'd2;
  localparam logic [1:0] B_RDDONE_ENC = 2'd3;

  typedef enum logic [1:0] {
    B_IDLE   = B_IDLE_ENC,
    B_WR     = B_WR_ENC,
    B_RD     = B_RD_ENC,
    B_RDDONE = B_RDDONE_ENC
  } bus_state_e;

  // Data returned to the core when a load is aborted by the bus timeout
  localparam logic [WORD_WIDTH-1:0] ABORT_RDATA = 32'hDEAD_BEEF;

  // One posted store held in the write buffer
  typedef struct packed {
    logic [WORD_WIDTH-1:0] addr;
    logic [WORD_WIDTH-1:0] data;
  } wbuf_entry_t;

  // Clear the byte-offset bits so the bus only ever sees word addresses
  function automatic logic [WORD_WIDTH-1:0] word_align(input logic [WORD_WIDTH-1:0] a);
    return a & ~(WORD_WIDTH'(3));
  endfunction

endpackage

// File: rtl/wr_buf.sv
// One-entry posted-store buffer; clear wins over load.
module wr_buf
  import dmem_bridge_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic                  clear_i,
  input  logic [WORD_WIDTH-1:0] addr_i,
  input  logic [WORD_WIDTH-1:0] data_i,
  output logic                  valid_o,
  output logic [WORD_WIDTH-1:0] addr_o,
  output logic [WORD_WIDTH-1:0] data_o
);

  logic        valid_q;
  wbuf_entry_t entry_q;

  // Capture a store when loaded, drop it when the bus is done with it
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      entry_q <= '0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q    <= 1'b1;
      entry_q.addr <= addr_i;
      entry_q.data <= data_i;
    end
  end

  assign valid_o = valid_q;
  assign addr_o  = entry_q.addr;
  assign data_o  = entry_q.data;

endmodule

// File: rtl/dmem_bridge.sv
// Bridges core load/store requests onto a single-outstanding external bus,
// posting stores through a one-entry buffer and aborting stuck transfers.
module dmem_bridge
  import dmem_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [WORD_WIDTH-1:0] mem_addr,
  input  logic [WORD_WIDTH-1:0] mem_wdata,
  output logic [WORD_WIDTH-1:0] mem_rdata,
  output logic                  mem_stall,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [WORD_WIDTH-1:0] bus_addr,
  output logic [WORD_WIDTH-1:0] bus_wdata,
  input  logic                  bus_ack,
  input  logic [WORD_WIDTH-1:0] bus_rdata,
  output logic                  bus_err
);

  // Counter only needs to reach TIMEOUT_CYC-1 before the abort fires
  localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  bus_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  bus_req_q, bus_req_d;
  logic                  bus_we_q, bus_we_d;
  logic                  bus_err_q, bus_err_d;
  logic [WORD_WIDTH-1:0] bus_addr_q, bus_addr_d;
  logic [WORD_WIDTH-1:0] bus_wdata_q, bus_wdata_d;
  logic [WORD_WIDTH-1:0] mem_rdata_q, mem_rdata_d;

  logic                  wbuf_valid;
  logic [WORD_WIDTH-1:0] wbuf_addr;
  logic [WORD_WIDTH-1:0] wbuf_data;
  logic                  wbuf_load;
  logic                  wbuf_clear;
  logic                  timeout;

  // A store is posted only when the buffer is free and no load competes
  assign wbuf_load = mem_write & ~mem_read & ~wbuf_valid;

  wr_buf u_wr_buf (
    .clk     (clk),
    .rst     (rst),
    .load_i  (wbuf_load),
    .clear_i (wbuf_clear),
    .addr_i  (mem_addr),
    .data_i  (mem_wdata),
    .valid_o (wbuf_valid),
    .addr_o  (wbuf_addr),
    .data_o  (wbuf_data)
  );

  // Loads wait for their data; stores wait only for a full buffer
  always_comb begin
    mem_stall = 1'b0;
    if (!rst) begin
      if (mem_read) begin
        mem_stall = (state_q != B_RDDONE);
      end else if (mem_write) begin
        mem_stall = wbuf_valid;
      end
    end
  end

  // Next-state and registered-output logic for the bus FSM
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_err_d   = bus_err_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    mem_rdata_d = mem_rdata_q;
    wbuf_clear  = 1'b0;
    timeout     = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    unique case (state_q)
      B_IDLE: begin
        // Pending stores drain before any load to keep program order
        if (wbuf_valid) begin
          state_d     = B_WR;
          cnt_d       = '0;
          bus_req_d   = 1'b1;
          bus_we_d    = 1'b1;
          bus_addr_d  = word_align(wbuf_addr);
          bus_wdata_d = wbuf_data;
        end else if (mem_read) begin
          state_d    = B_RD;
          cnt_d      = '0;
          bus_req_d  = 1'b1;
          bus_we_d   = 1'b0;
          bus_addr_d = word_align(mem_addr);
        end
      end
      B_WR: begin
        if (bus_ack || timeout) begin
          state_d    = B_IDLE;
          bus_req_d  = 1'b0;
          bus_we_d   = 1'b0;
          wbuf_clear = 1'b1;
          if (!bus_ack) begin
            bus_err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      B_RD: begin
        if (bus_ack) begin
          state_d     = B_RDDONE;
          bus_req_d   = 1'b0;
          mem_rdata_d = bus_rdata;
        end else if (timeout) begin
          state_d     = B_RDDONE;
          bus_req_d   = 1'b0;
          bus_err_d   = 1'b1;
          mem_rdata_d = ABORT_RDATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      B_RDDONE: begin
        state_d = B_IDLE;
      end
      default: begin
        state_d = B_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= B_IDLE;
      cnt_q       <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_err_q   <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_err_q   <= bus_err_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_err   = bus_err_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign mem_rdata = mem_rdata_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed cycle-by-cycle bench for dmem_bridge (TIMEOUT_CYC = 8).
// Inputs change 1ns after each rising edge; outputs are checked on the falling edge.
module tb_dmem_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_stall;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        bus_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dmem_bridge #(.TIMEOUT_CYC(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_stall (mem_stall),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_ack   (bus_ack),
    .bus_rdata (bus_rdata),
    .bus_err   (bus_err)
  );

  task automatic test_reset();
    rst = 1'b1; mem_read = 1'b1; mem_write = 1'b1; bus_ack = 1'b1;
    mem_addr = 32'hFFFF_FFFF; mem_wdata = 32'h1234_5678; bus_rdata = 32'h8765_4321;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++; if (mem_stall !== 1'b0) begin n_fail++; $display("FAIL reset stall: got %b exp 0", mem_stall); end
    n_checks++; if (bus_req !== 1'b0) begin n_fail++; $display("FAIL reset bus_req: got %b exp 0", bus_req); end
    n_checks++; if (bus_we !== 1'b0) begin n_fail++; $display("FAIL reset bus_we: got %b exp 0", bus_we); end
    n_checks++; if (bus_addr !== 32'h0) begin n_fail++; $display("FAIL reset bus_addr: got %h exp 0", bus_addr); end
    n_checks++; if (bus_wdata !== 32'h0) begin n_fail++; $display("FAIL reset bus_wdata: got %h exp 0", bus_wdata); end
    n_checks++; if (mem_rdata !== 32'h0) begin n_fail++; $display("FAIL reset mem_rdata: got %h exp 0", mem_rdata); end
    n_checks++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL reset bus_err: got %b exp 0", bus_err); end
    @(posedge clk); #1;
    rst = 1'b0; mem_read = 1'b0; mem_write = 1'b0; bus_ack = 1'b0; bus_rdata = 32'h0;
    @(negedge clk);
    n_checks++; if (bus_req !== 1'b0) begin n_fail++; $display("FAIL reset post bus_req: got %b exp 0", bus_req); end
    @(posedge clk); #1;
  endtask

  // Store to 0x13 is posted without stall; bus holds word address 0x10 for 3 cycles
  task automatic test_store_posted();
    logic [0:5] wr_v = 6'b100000;
    logic [0:5] ak_v = 6'b000010;
    logic [0:5] st_v = 6'b000000;
    logic [0:5] rq_v = 6'b001110;
    logic [0:5] we_v = 6'b001110;
    mem_addr = 32'h0000_0013; mem_wdata = 32'hCAFE_0001;
    for (int i = 0; i < 6; i++) begin
      mem_write = wr_v[i]; bus_ack = ak_v[i];
      @(negedge clk);
      n_checks++; if (mem_stall !== st_v[i]) begin n_fail++; $display("FAIL store_posted stall c%0d: got %b exp %b", i, mem_stall, st_v[i]); end
      n_checks++; if (bus_req !== rq_v[i]) begin n_fail++; $display("FAIL store_posted bus_req c%0d: got %b exp %b", i, bus_req, rq_v[i]); end
      n_checks++; if (bus_we !== we_v[i]) begin n_fail++; $display("FAIL store_posted bus_we c%0d: got %b exp %b", i, bus_we, we_v[i]); end
      if (rq_v[i]) begin
        n_checks++; if (bus_addr !== 32'h0000_0010) begin n_fail++; $display("FAIL store_posted bus_addr c%0d: got %h exp 00000010", i, bus_addr); end
        n_checks++; if (bus_wdata !== 32'hCAFE_0001) begin n_fail++; $display("FAIL store_posted bus_wdata c%0d: got %h exp cafe0001", i, bus_wdata); end
      end
      @(posedge clk); #1;
    end
    mem_write = 1'b0; bus_ack = 1'b0;
  endtask

  // Load right after a store waits for the store to drain, then reads 0x10
  task automatic test_store_then_load();
    logic [0:8] wr_v = 9'b100000000;
    logic [0:8] rd_v = 9'b011111110;
    logic [0:8] ak_v = 9'b000100100;
    logic [0:8] st_v = 9'b011111100;
    logic [0:8] rq_v = 9'b001101100;
    logic [0:8] we_v = 9'b001100000;
    mem_addr = 32'h0000_0010; mem_wdata = 32'h1111_2222;
    for (int i = 0; i < 9; i++) begin
      mem_write = wr_v[i]; mem_read = rd_v[i]; bus_ack = ak_v[i];
      bus_rdata = (i == 6) ? 32'hA5A5_1234 : 32'h0;
      @(negedge clk);
      n_checks++; if (mem_stall !== st_v[i]) begin n_fail++; $display("FAIL st_ld stall c%0d: got %b exp %b", i, mem_stall, st_v[i]); end
      n_checks++; if (bus_req !== rq_v[i]) begin n_fail++; $display("FAIL st_ld bus_req c%0d: got %b exp %b", i, bus_req, rq_v[i]); end
      n_checks++; if (bus_we !== we_v[i]) begin n_fail++; $display("FAIL st_ld bus_we c%0d: got %b exp %b", i, bus_we, we_v[i]); end
      if (i == 5) begin
        n_checks++; if (bus_addr !== 32'h0000_0010) begin n_fail++; $display("FAIL st_ld rd bus_addr: got %h exp 00000010", bus_addr); end
      end
      if (i >= 7) begin
        n_checks++; if (mem_rdata !== 32'hA5A5_1234) begin n_fail++; $display("FAIL st_ld mem_rdata c%0d: got %h exp a5a51234", i, mem_rdata); end
      end
      @(posedge clk); #1;
    end
    mem_read = 1'b0; mem_write = 1'b0; bus_ack = 1'b0;
  endtask

  // Second store stalls 4 cycles and is accepted the cycle after the first ack
  task automatic test_back_to_back();
    logic [0:8] wr_v = 9'b111111000;
    logic [0:8] ak_v = 9'b000010010;
    logic [0:8] st_v = 9'b011110000;
    logic [0:8] rq_v = 9'b001110010;
    logic [31:0] exp_a;
    logic [31:0] exp_d;
    for (int i = 0; i < 9; i++) begin
      mem_write = wr_v[i]; bus_ack = ak_v[i];
      mem_addr  = (i == 0) ? 32'h0000_0020 : 32'h0000_0024;
      mem_wdata = (i == 0) ? 32'h1111_1111 : 32'h2222_2222;
      exp_a     = (i < 5) ? 32'h0000_0020 : 32'h0000_0024;
      exp_d     = (i < 5) ? 32'h1111_1111 : 32'h2222_2222;
      @(negedge clk);
      n_checks++; if (mem_stall !== st_v[i]) begin n_fail++; $display("FAIL b2b stall c%0d: got %b exp %b", i, mem_stall, st_v[i]); end
      n_checks++; if (bus_req !== rq_v[i]) begin n_fail++; $display("FAIL b2b bus_req c%0d: got %b exp %b", i, bus_req, rq_v[i]); end
      n_checks++; if (bus_we !== rq_v[i]) begin n_fail++; $display("FAIL b2b bus_we c%0d: got %b exp %b", i, bus_we, rq_v[i]); end
      if (rq_v[i]) begin
        n_checks++; if (bus_addr !== exp_a) begin n_fail++; $display("FAIL b2b bus_addr c%0d: got %h exp %h", i, bus_addr, exp_a); end
        n_checks++; if (bus_wdata !== exp_d) begin n_fail++; $display("FAIL b2b bus_wdata c%0d: got %h exp %h", i, bus_wdata, exp_d); end
      end
      @(posedge clk); #1;
    end
    mem_write = 1'b0; bus_ack = 1'b0;
  endtask

  // Read and write together behave as a 3-cycle read; the store is dropped
  task automatic test_read_priority();
    logic [0:4] rd_v = 5'b11100;
    logic [0:4] ak_v = 5'b01000;
    logic [0:4] st_v = 5'b11000;
    logic [0:4] rq_v = 5'b01000;
    mem_addr = 32'h0000_0103; mem_wdata = 32'h7777_7777;
    for (int i = 0; i < 5; i++) begin
      mem_read = rd_v[i]; mem_write = rd_v[i]; bus_ack = ak_v[i];
      bus_rdata = (i == 1) ? 32'h5A5A_0F0F : 32'hFFFF_0000;
      @(negedge clk);
      n_checks++; if (mem_stall !== st_v[i]) begin n_fail++; $display("FAIL rdprio stall c%0d: got %b exp %b", i, mem_stall, st_v[i]); end
      n_checks++; if (bus_req !== rq_v[i]) begin n_fail++; $display("FAIL rdprio bus_req c%0d: got %b exp %b", i, bus_req, rq_v[i]); end
      n_checks++; if (bus_we !== 1'b0) begin n_fail++; $display("FAIL rdprio bus_we c%0d: got %b exp 0", i, bus_we); end
      if (i == 1) begin
        n_checks++; if (bus_addr !== 32'h0000_0100) begin n_fail++; $display("FAIL rdprio bus_addr: got %h exp 00000100", bus_addr); end
      end
      if (i == 2) begin
        n_checks++; if (mem_rdata !== 32'h5A5A_0F0F) begin n_fail++; $display("FAIL rdprio mem_rdata: got %h exp 5a5a0f0f", mem_rdata); end
      end
      @(posedge clk); #1;
    end
    mem_read = 1'b0; mem_write = 1'b0; bus_ack = 1'b0;
  endtask

  // Unacknowledged load aborts after 8 bus cycles with DEADBEEF; later acks ignored
  task automatic test_timeout_read();
    logic [0:11] rd_v = 12'b111111111100;
    logic [0:11] ak_v = 12'b000000000110;
    logic [0:11] st_v = 12'b111111111000;
    logic [0:11] rq_v = 12'b011111111000;
    mem_addr = 32'h0000_0044;
    for (int i = 0; i < 12; i++) begin
      mem_read = rd_v[i]; bus_ack = ak_v[i]; bus_rdata = 32'h3333_3333;
      @(negedge clk);
      n_checks++; if (mem_stall !== st_v[i]) begin n_fail++; $display("FAIL timeout stall c%0d: got %b exp %b", i, mem_stall, st_v[i]); end
      n_checks++; if (bus_req !== rq_v[i]) begin n_fail++; $display("FAIL timeout bus_req c%0d: got %b exp %b", i, bus_req, rq_v[i]); end
      if (i == 8) begin
        n_checks++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL timeout early bus_err: got %b exp 0", bus_err); end
      end
      if (i >= 9) begin
        n_checks++; if (bus_err !== 1'b1) begin n_fail++; $display("FAIL timeout bus_err c%0d: got %b exp 1", i, bus_err); end
        n_checks++; if (mem_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL timeout mem_rdata c%0d: got %h exp deadbeef", i, mem_rdata); end
      end
      @(posedge clk); #1;
    end
    mem_read = 1'b0; bus_ack = 1'b0;
  endtask

  // Reset during B_RD drops the request, clears outputs, ignores a late ack
  task automatic test_reset_mid_read();
    logic [0:7] rs_v = 8'b00100000;
    logic [0:7] rd_v = 8'b11101110;
    logic [0:7] ak_v = 8'b00010100;
    logic [0:7] st_v = 8'b11001100;
    logic [0:7] rq_v = 8'b01100100;
    for (int i = 0; i < 8; i++) begin
      rst = rs_v[i]; mem_read = rd_v[i]; bus_ack = ak_v[i];
      mem_addr  = (i < 3) ? 32'h0000_0080 : 32'h0000_0084;
      bus_rdata = (i == 5) ? 32'h0BAD_F00D : 32'h1234_5678;
      @(negedge clk);
      n_checks++; if (mem_stall !== st_v[i]) begin n_fail++; $display("FAIL rstrd stall c%0d: got %b exp %b", i, mem_stall, st_v[i]); end
      n_checks++; if (bus_req !== rq_v[i]) begin n_fail++; $display("FAIL rstrd bus_req c%0d: got %b exp %b", i, bus_req, rq_v[i]); end
      if (i == 3) begin
        n_checks++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL rstrd bus_err: got %b exp 0", bus_err); end
        n_checks++; if (bus_addr !== 32'h0) begin n_fail++; $display("FAIL rstrd bus_addr: got %h exp 0", bus_addr); end
        n_checks++; if (bus_wdata !== 32'h0) begin n_fail++; $display("FAIL rstrd bus_wdata: got %h exp 0", bus_wdata); end
        n_checks++; if (bus_we !== 1'b0) begin n_fail++; $display("FAIL rstrd bus_we: got %b exp 0", bus_we); end
      end
      if (i == 3 || i == 4) begin
        n_checks++; if (mem_rdata !== 32'h0) begin n_fail++; $display("FAIL rstrd mem_rdata c%0d: got %h exp 0", i, mem_rdata); end
      end
      if (i == 5) begin
        n_checks++; if (bus_addr !== 32'h0000_0084) begin n_fail++; $display("FAIL rstrd reload bus_addr: got %h exp 00000084", bus_addr); end
      end
      if (i >= 6) begin
        n_checks++; if (mem_rdata !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL rstrd reload mem_rdata c%0d: got %h exp 0badf00d", i, mem_rdata); end
      end
      @(posedge clk); #1;
    end
    rst = 1'b0; mem_read = 1'b0; bus_ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_store_posted();
    test_store_then_load();
    test_back_to_back();
    test_read_priority();
    test_timeout_read();
    test_reset_mid_read();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
